// File: rtl/zuc_nlf_if.sv
// Bus between the bit-reorganisation stage (master) and the ZUC F stage (slave).
interface zuc_nlf_if;
    // in_vld qualifies x0/x1/x2 for one F step; there is no ready, the stage takes
    // every valid step. w_vld marks w for exactly one cycle and the consumer must take it.
    logic        clr;
    logic        in_vld;
    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        w_vld;
    logic [31:0] w;
    logic [31:0] r1;
    logic [31:0] r2;

    modport master (output clr, in_vld, x0, x1, x2, input w_vld, w, r1, r2);
    modport slave  (input clr, in_vld, x0, x1, x2, output w_vld, w, r1, r2);
endinterface

// File: rtl/zuc_nlf.sv
// ZUC nonlinear function F: memory cells R1/R2, registered W output, S-box layer
// built from two S0/S1 byte pairs per register path.
module zuc_nlf (
    input  logic      clk,
    input  logic      rst,
    zuc_nlf_if.slave  bus
);

    // Tables are stored entry 0 in the most significant byte.
    localparam logic [2047:0] S0_TAB = {
        128'h3e725b47_cae00033_04d15498_09b96dcb, 128'h7b1bf932_af9d6aa5_b82dfc1d_08530390,
        128'h4d4e8499_e4ced991_ddb68548_8b296eac, 128'hcdc1f81e_734369c6_b5bdfd39_6320d438,
        128'h767db2a7_cfed57c5_f32cbb14_2106559b, 128'he3ef5e31_4f7f5aa4_0d825149_5fba581c,
        128'h4a16d517_a892241f_8cffd8ae_2e01d3ad, 128'h3b4bda46_ebc9de9a_8f87d73a_806f2fc8,
        128'hb1b437f7_0a221328_7ccc3c89_c7c39656, 128'h07bf7ef0_0b2b9752_35417961_a64c10fe,
        128'hbc269588_8ab0a3fb_c01894f2_e1e5e95d, 128'hd0dc1166_645cec59_427512f5_749caa23,
        128'h0e86abbe_2a02e767_e644a26c_c2939ff1, 128'hf6fa36d2_50689e62_71153dd6_40c4e20f,
        128'h8e83776b_25053f0c_30ea70b7_a1e8a965, 128'h8d271adb_81b3a0f4_457a19df_ee783460
    };

    localparam logic [2047:0] S1_TAB = {
        128'h55c26371_3bc84786_9f3cda5b_29aafd77, 128'h8cc5940c_a61a1300_e3a81672_40f9f842,
        128'h44266896_81d9453e_1076c6a7_8b3943e1, 128'h3ab5562a_c06db305_2266bfdc_0bfa6248,
        128'hdd201106_36c9c1cf_f62752bb_69f5d487, 128'h7f844cd2_9c57a4bc_4f9adffe_d68d7aeb,
        128'h2b53d85c_a11417fb_23d57d30_67730809, 128'heeb7703f_61b2198e_4ee54b93_8f5ddba9,
        128'hadf1ae2e_cb0dfcf4_2d466e1d_97e8d1e9, 128'h4d37a575_5e839eab_829db91c_e0cd4989,
        128'h01b6bd58_24a25f38_78991590_50b895e4, 128'hd091c7ce_ed0fb46f_a0ccf002_4a79c3de,
        128'ha3efea51_e66b18ec_1b2c80f7_74e7ff21, 128'h5a6a541e_41319235_c433070a_ba7e0e34,
        128'h88b1987c_f33d606c_7bcad31f_32650428, 128'h64be859b_2f598ad7_b025acaf_1203e2f2
    };

    // Entry a sits at bit 2047 - 8*a, which is {~a, 3'b111}.
    function automatic logic [7:0] zuc_s0(input logic [7:0] a);
        return S0_TAB[{~a, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] zuc_s1(input logic [7:0] a);
        return S1_TAB[{~a, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sbox32(input logic [31:0] y);
        return {zuc_s0(y[31:24]), zuc_s1(y[23:16]), zuc_s0(y[15:8]), zuc_s1(y[7:0])};
    endfunction

    function automatic logic [31:0] l1(input logic [31:0] x);
        return x ^ {x[29:0], x[31:30]} ^ {x[21:0], x[31:22]}
                 ^ {x[13:0], x[31:14]} ^ {x[7:0], x[31:8]};
    endfunction

    function automatic logic [31:0] l2(input logic [31:0] x);
        return x ^ {x[23:0], x[31:24]} ^ {x[17:0], x[31:18]}
                 ^ {x[9:0], x[31:10]} ^ {x[1:0], x[31:2]};
    endfunction

    logic [31:0] r1_q;
    logic [31:0] r2_q;
    logic [31:0] w_q;
    logic        w_vld_q;

    logic [31:0] w_c;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] r1_nxt;
    logic [31:0] r2_nxt;

    always_comb begin
        w_c    = (bus.x0 ^ r1_q) + r2_q;
        w1     = r1_q + bus.x1;
        w2     = r2_q ^ bus.x2;
        r1_nxt = sbox32(l1({w1[15:0], w2[31:16]}));
        r2_nxt = sbox32(l2({w2[15:0], w1[31:16]}));
    end

    // IDLE vs RUN is implicit: R1/R2 are zero until the first accepted step.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r1_q    <= '0;
            r2_q    <= '0;
            w_q     <= '0;
            w_vld_q <= 1'b0;
        end else begin
            w_vld_q <= bus.in_vld;
            if (bus.in_vld) begin
                w_q  <= w_c;
                r1_q <= r1_nxt;
                r2_q <= r2_nxt;
            end
        end
    end

    assign bus.w     = w_q;
    assign bus.w_vld = w_vld_q;
    assign bus.r1    = r1_q;
    assign bus.r2    = r2_q;

endmodule
